jk_bank_ctrl: RTL and testbench

Command-driven controller for a bank of WIDTH JK flip-flops (external j/k/q per bit). It accepts one command at a time over a valid/ready handshake and drives per-bit J and K each cycle to clear, set, load, toggle, or count the bank up or down. It observes the bank's Q outputs to compute counter toggle masks. It pulses done when the command's last bank update has taken effect.

---
 rtl/jk_bank_ctrl.sv | 154 +++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of external JK flip-flops.
// Issues clear/set/load/toggle in one cycle, or counts the bank up/down for N steps.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COUNT} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_TOG  = 3'b100;
  localparam logic [2:0] OP_UP   = 3'b101;
  localparam logic [2:0] OP_DN   = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic [WIDTH-1:0] t_mask;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          case (cmd_op)
            OP_NOP: done_d = 1'b1;
            OP_ILL: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
            OP_CLR, OP_SET, OP_LOAD, OP_TOG: state_d = S_APPLY;
            default: begin
              if (cmd_count == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_COUNT;
                rem_d   = cmd_count;
              end
            end
          endcase
        end
      end
      S_APPLY: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_COUNT: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Ripple-carry toggle mask: bit i flips when every lower bit is at its carry/borrow value.
  always_comb begin
    t_mask    = '0;
    t_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if (op_q == OP_DN) t_mask[i] = t_mask[i-1] & ~q_in[i-1];
      else               t_mask[i] = t_mask[i-1] &  q_in[i-1];
    end
  end

  always_comb begin
    j_out = '0;
    k_out = '0;
    if (!rst) begin
      case (state_q)
        S_APPLY: begin
          case (op_q)
            OP_CLR:  k_out = '1;
            OP_SET:  j_out = '1;
            OP_LOAD: begin
              j_out = data_q;
              k_out = ~data_q;
            end
            OP_TOG: begin
              j_out = data_q;
              k_out = data_q;
            end
            default: ;
          endcase
        end
        S_COUNT: begin
          j_out = t_mask;
          k_out = t_mask;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: models the JK bank and checks every command against
// the expected bank value, toggle masks and done/err timing.
module tb_jk_bank_ctrl;
  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [C-1:0] cmd_count;
  logic [W-1:0] j_out, k_out;
  logic         busy, done, err;
  logic [W-1:0] bank = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // The external JK flip-flop bank.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j_out[i], k_out[i]})
        2'b10: bank[i] <= 1'b1;
        2'b01: bank[i] <= 1'b0;
        2'b11: bank[i] <= ~bank[i];
        default: ;
      endcase
    end
  end

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .q_in(bank),
    .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check it end to end against a value-level model.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [C-1:0] n);
    logic [W-1:0] start, expv, cur, tm;
    int lat;
    bit ill, cnt, dn;
    int waited;
    start = bank;
    ill = (op == 3'b111);
    cnt = (op == 3'b101 || op == 3'b110);
    dn  = (op == 3'b110);
    case (op)
      3'b001:  begin expv = '0;        lat = 1; end
      3'b010:  begin expv = '1;        lat = 1; end
      3'b011:  begin expv = d;         lat = 1; end
      3'b100:  begin expv = start ^ d; lat = 1; end
      3'b101:  begin expv = W'((int'(start) + int'(n)) % (1 << W)); lat = int'(n); end
      3'b110:  begin expv = W'((int'(start) - int'(n) + 256 * (1 << W)) % (1 << W)); lat = int'(n); end
      default: begin expv = start;     lat = 0; end
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = n;
    waited = 0;
    while (!cmd_ready && waited < 300) begin tick(); waited++; end
    checks++;
    if (!cmd_ready) $display("FAIL ready_wait op=%0d: cmd_ready=%b required 1", op, cmd_ready);
    else passes++;
    tick();
    cmd_valid = 1'b0;
    for (int t = 0; t < lat; t++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) $display("FAIL busy_phase op=%0d t=%0d: busy=%b done=%b required 1/0", op, t, busy, done);
      else passes++;
      if (cnt) begin
        cur = dn ? W'(start - W'(t)) : W'(start + W'(t));
        tm  = dn ? (cur ^ W'(cur - 1'b1)) : (cur ^ W'(cur + 1'b1));
        checks++;
        if (bank !== cur || j_out !== tm || k_out !== tm)
          $display("FAIL count_step op=%0d t=%0d: q=%b j=%b k=%b required q=%b j=k=%b", op, t, bank, j_out, k_out, cur, tm);
        else passes++;
      end else begin
        checks++;
        if (bank !== start) $display("FAIL apply_hold op=%0d: q=%b required %b", op, bank, start);
        else passes++;
        // APPLY drive: j must set the target ones, k must clear the target zeros.
        checks++;
        if (op == 3'b100) begin
          if (j_out !== d || k_out !== d) $display("FAIL apply_jk op=%0d: j=%b k=%b required j=k=%b", op, j_out, k_out, d);
          else passes++;
        end else begin
          if (j_out !== expv || k_out !== ~expv) $display("FAIL apply_jk op=%0d: j=%b k=%b required %b/%b", op, j_out, k_out, expv, ~expv);
          else passes++;
        end
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || err !== ill || bank !== expv || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL complete op=%0d n=%0d: done=%b err=%b q=%b ready=%b busy=%b required 1/%b/%b/1/0",
               op, n, done, err, bank, cmd_ready, busy, ill, expv);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || bank !== expv)
      $display("FAIL pulse_end op=%0d: done=%b err=%b q=%b required 0/0/%b", op, done, err, bank, expv);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || j_out !== '0 || k_out !== '0) $display("FAIL reset_hold: ready=%b j=%b k=%b required 0/0/0", cmd_ready, j_out, k_out);
    else passes++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (j_out !== '0 || k_out !== '0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset_state: j=%b k=%b done=%b err=%b busy=%b ready=%b required 0/0/0/0/0/1", j_out, k_out, done, err, busy, cmd_ready);
    else passes++;
    tick(); tick();
    checks++;
    if (bank !== 4'b0000) $display("FAIL reset_bank: q=%b required 0000", bank);
    else passes++;
  endtask

  task automatic test_single_ops();
    run_cmd(3'b011, 4'b1010, '0);
    run_cmd(3'b010, 4'b0000, '0);
    run_cmd(3'b001, 4'b1111, '0);
    run_cmd(3'b100, 4'b1001, '0);
    run_cmd(3'b000, 4'b0110, '0);
  endtask

  task automatic test_count();
    run_cmd(3'b011, 4'b1110, '0);
    run_cmd(3'b101, 4'b0000, 8'd3);
    run_cmd(3'b011, 4'b0001, '0);
    run_cmd(3'b110, 4'b0000, 8'd2);
    run_cmd(3'b101, 4'b0000, 8'd0);
    run_cmd(3'b110, 4'b0000, 8'd17);
  endtask

  task automatic test_back_to_back();
    run_cmd(3'b011, 4'b1011, '0);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_data = 4'b0000; cmd_count = '0;
    tick();
    cmd_op = 3'b100; cmd_data = 4'b0110;
    tick();
    checks++;
    if (done !== 1'b1 || bank !== 4'b0000 || cmd_ready !== 1'b1) $display("FAIL b2b_first: done=%b q=%b ready=%b required 1/0000/1", done, bank, cmd_ready);
    else passes++;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || j_out !== 4'b0110 || k_out !== 4'b0110)
      $display("FAIL b2b_apply: done=%b busy=%b j=%b k=%b required 0/1/0110/0110", done, busy, j_out, k_out);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b1 || bank !== 4'b0110) $display("FAIL b2b_second: done=%b q=%b required 1/0110", done, bank);
    else passes++;
    tick();
    run_cmd(3'b111, 4'b1111, 8'd9);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    run_cmd(3'b001, 4'b0000, '0);
    cmd_valid = 1'b1; cmd_op = 3'b101; cmd_data = '0; cmd_count = 8'd200;
    tick();
    cmd_valid = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin tick(); if (done) seen_done = 1'b1; end
    rst = 1'b1;
    #1;
    checks++;
    if (j_out !== '0 || k_out !== '0 || cmd_ready !== 1'b0 || bank !== 4'b0101)
      $display("FAIL rst_mid_drive: j=%b k=%b ready=%b q=%b required 0/0/0/0101", j_out, k_out, cmd_ready, bank);
    else passes++;
    tick();
    if (done) seen_done = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (bank !== 4'b0101 || cmd_ready !== 1'b1 || busy !== 1'b0 || seen_done)
      $display("FAIL rst_mid_after: q=%b ready=%b busy=%b done_seen=%b required 0101/1/0/0", bank, cmd_ready, busy, seen_done);
    else passes++;
    tick();
    checks++;
    if (bank !== 4'b0101 || done !== 1'b0) $display("FAIL rst_mid_hold: q=%b done=%b required 0101/0", bank, done);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [W-1:0] d;
      logic [C-1:0] n;
      op = 3'($urandom_range(0, 7));
      d  = W'($urandom);
      n  = ($urandom_range(0, 5) == 0) ? '0 : C'($urandom_range(1, 20));
      run_cmd(op, d, n);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_count();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
